// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch with branch redirect, stall hold and halt-opcode detection
module fetch_controller #(
    parameter logic [4:0] HALT_OP = 5'b01011,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             flush,
    output logic             done,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d, instr_q, instr_d;
    logic             valid_q, valid_d, flush_q, flush_d, done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_halt, restart;
    assign is_halt = imem_data[31:27] == HALT_OP;
    assign restart = start && (state_q == IDLE || state_q == HALT);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end
    // Redirect beats stall beats halt detect beats a normal issue; HALT ignores everything but start.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (restart) begin
            state_d = RUN;
            pc_d    = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            if (branch_taken) begin
                pc_d    = branch_target;
                valid_d = 1'b0;
                flush_d = 1'b1;
            end else if (!stall) begin
                if (is_halt) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd1;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
        end
    end
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign flush       = flush_q;
    assign done        = done_q;
    assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vector table plus hand sequences for the saturating counter
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr, imem_data, instr;
    logic        instr_valid, flush, done;
    logic [15:0] fetch_count;
    logic [31:0] imem_addr2, imem_data2, instr2;
    logic        instr_valid2, flush2, done2;
    logic [1:0]  fetch_count2;
    logic [31:0] mem [64];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign imem_data  = mem[imem_addr[5:0]];
    assign imem_data2 = mem[imem_addr2[5:0]];

    fetch_controller dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
        .instr_valid(instr_valid), .flush(flush), .done(done), .fetch_count(fetch_count)
    );
    fetch_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .instr(instr2),
        .instr_valid(instr_valid2), .flush(flush2), .done(done2), .fetch_count(fetch_count2)
    );

    typedef struct packed {
        logic        rst, start, stall, br;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        v, f, d;
        logic [15:0] cnt;
        logic [31:0] instr;
    } vec_t;

    function automatic vec_t mk(input logic r, s, st, b, input logic [31:0] t, a,
                                input logic v, f, d, input logic [15:0] c, input logic [31:0] i);
        vec_t x;
        x.rst = r; x.start = s; x.stall = st; x.br = b; x.tgt = t;
        x.addr = a; x.v = v; x.f = f; x.d = d; x.cnt = c; x.instr = i;
        return x;
    endfunction

    task automatic check(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endtask

    task automatic step(input logic r, s, st, b, input logic [31:0] t);
        rst = r; start = s; stall = st; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] H = 32'h5800_0000;
    vec_t vt [28];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_1000 + 32'(i);
        mem[4] = H;
        //           rst start stall br  tgt            addr           v f d cnt instr
        vt[0]  = mk(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
        vt[1]  = mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
        vt[2]  = mk(0, 1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
        vt[3]  = mk(0, 0, 0, 0, 32'h0,        32'h1,        1, 0, 0, 1, 32'h1000);
        vt[4]  = mk(0, 0, 0, 0, 32'h0,        32'h2,        1, 0, 0, 2, 32'h1001);
        vt[5]  = mk(0, 0, 0, 0, 32'h0,        32'h3,        1, 0, 0, 3, 32'h1002);
        vt[6]  = mk(0, 0, 0, 0, 32'h0,        32'h4,        1, 0, 0, 4, 32'h1003);
        vt[7]  = mk(0, 0, 0, 0, 32'h0,        32'h4,        0, 0, 1, 4, 32'h1003);
        vt[8]  = mk(0, 0, 1, 1, 32'h20,       32'h4,        0, 0, 1, 4, 32'h1003);
        vt[9]  = mk(0, 1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h1003);
        vt[10] = mk(0, 1, 0, 0, 32'h0,        32'h1,        1, 0, 0, 1, 32'h1000);
        vt[11] = mk(0, 0, 0, 0, 32'h0,        32'h2,        1, 0, 0, 2, 32'h1001);
        vt[12] = mk(0, 0, 0, 1, 32'h10,       32'h10,       0, 1, 0, 2, 32'h1001);
        vt[13] = mk(0, 0, 0, 0, 32'h0,        32'h11,       1, 0, 0, 3, 32'h1010);
        vt[14] = mk(0, 0, 1, 1, 32'h20,       32'h20,       0, 1, 0, 3, 32'h1010);
        vt[15] = mk(0, 0, 0, 1, 32'h5,        32'h5,        0, 1, 0, 3, 32'h1010);
        vt[16] = mk(0, 0, 1, 0, 32'h0,        32'h5,        0, 0, 0, 3, 32'h1010);
        vt[17] = mk(0, 0, 1, 0, 32'h0,        32'h5,        0, 0, 0, 3, 32'h1010);
        vt[18] = mk(0, 0, 1, 0, 32'h0,        32'h5,        0, 0, 0, 3, 32'h1010);
        vt[19] = mk(0, 0, 0, 0, 32'h0,        32'h6,        1, 0, 0, 4, 32'h1005);
        vt[20] = mk(0, 0, 1, 0, 32'h0,        32'h6,        1, 0, 0, 4, 32'h1005);
        vt[21] = mk(0, 0, 0, 0, 32'h0,        32'h7,        1, 0, 0, 5, 32'h1006);
        vt[22] = mk(1, 1, 1, 1, 32'h30,       32'h0,        0, 0, 0, 0, 32'h0);
        vt[23] = mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
        vt[24] = mk(0, 1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0);
        vt[25] = mk(0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0);
        vt[26] = mk(0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 32'h103F);
        vt[27] = mk(0, 0, 0, 0, 32'h0,        32'h1,        1, 0, 0, 2, 32'h1000);

        for (int i = 0; i < 28; i++) begin
            logic [1:0] c2;
            step(vt[i].rst, vt[i].start, vt[i].stall, vt[i].br, vt[i].tgt);
            check(imem_addr == vt[i].addr && instr_valid == vt[i].v && flush == vt[i].f &&
                  done == vt[i].d && fetch_count == vt[i].cnt && instr == vt[i].instr,
                  $sformatf("vec%0d got addr=%h v=%b f=%b d=%b cnt=%0d instr=%h want addr=%h v=%b f=%b d=%b cnt=%0d instr=%h",
                            i, imem_addr, instr_valid, flush, done, fetch_count, instr,
                            vt[i].addr, vt[i].v, vt[i].f, vt[i].d, vt[i].cnt, vt[i].instr));
            c2 = (vt[i].cnt > 16'd3) ? 2'd3 : vt[i].cnt[1:0];
            check(fetch_count2 == c2,
                  $sformatf("vec%0d cnt2 got %0d want %0d", i, fetch_count2, c2));
        end

        // Five back-to-back issues from a halt-free region: narrow counter must saturate.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h8);
        check(fetch_count2 == 2'd0 && flush2 == 1'b1,
              $sformatf("sat_redirect got cnt2=%0d flush2=%b want 0 1", fetch_count2, flush2));
        for (int k = 1; k <= 5; k++) begin
            logic [1:0] w2;
            w2 = (k > 3) ? 2'd3 : 2'(k);
            step(0, 0, 0, 0, 0);
            check(fetch_count2 == w2 && fetch_count == 16'(k) && imem_addr == 32'h8 + 32'(k),
                  $sformatf("sat_issue%0d got cnt2=%0d cnt=%0d addr=%h want %0d %0d %h",
                            k, fetch_count2, fetch_count, imem_addr, w2, k, 32'h8 + 32'(k)));
        end

        // Flush is a single pulse after one redirect, even under stall.
        step(0, 0, 1, 1, 32'h3);
        step(0, 0, 1, 0, 0);
        check(flush == 1'b0 && imem_addr == 32'h3 && instr_valid == 1'b0,
              $sformatf("flush_pulse got flush=%b addr=%h v=%b want 0 3 0", flush, imem_addr, instr_valid));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check(done == 1'b1 && imem_addr == 32'h4 && instr_valid == 1'b0 && fetch_count == 16'd6,
              $sformatf("halt_after_redirect got d=%b addr=%h v=%b cnt=%0d want 1 4 0 6",
                        done, imem_addr, instr_valid, fetch_count));
        step(0, 0, 0, 0, 0);
        check(done == 1'b1 && imem_addr == 32'h4 && fetch_count == 16'd6,
              $sformatf("halt_hold got d=%b addr=%h cnt=%0d want 1 4 6", done, imem_addr, fetch_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter HALT_OP, default 5'b01011: opcode in bits [31:27] that terminates fetch.
REQ-002 Parameter CNT_W, default 16: width of fetch counter.
REQ-003 clk  in  1: single clock; all state changes on rising edge.
REQ-004 rst  in  1: synchronous, active-high reset.
REQ-005 start  in  1: begin or restart fetch from address 0 when in IDLE or HALT.
REQ-006 stall  in  1: hazard hold; freezes pc and instruction outputs.
REQ-007 branch_taken  in  1: redirect request, valid this cycle.
REQ-008 branch_target  in  32: word address to redirect to.
REQ-009 imem_addr  out  32: current pc, drives instruction memory; memory returns data combinationally.
REQ-010 imem_data  in  32: instruction word at imem_addr.
REQ-011 instr  out  32: registered instruction to decode.
REQ-012 instr_valid  out  1: instr holds a real instruction this cycle.
REQ-013 flush  out  1: one-cycle pulse, downstream discards in-flight instruction.
REQ-014 done  out  1: program reached HALT_OP; held until restart/reset.
REQ-015 fetch_count  out  CNT_W: number of instructions issued since start, saturating.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALT; encoding free.
REQ-017 IDLE: pc holds 0, instr_valid=0; start=1 -> RUN next cycle with pc=0, fetch_count=0.
REQ-018 RUN priority per cycle SHALL be: branch_taken > stall > halt detect > normal fetch.
REQ-019 RUN normal (no branch, no stall, imem_data[31:27]!=HALT_OP): instr<=imem_data, instr_valid<=1, pc<=pc+1, fetch_count<=fetch_count+1.
REQ-020 RUN branch_taken=1: pc<=branch_target, instr_valid<=0, flush=1 for exactly that next cycle, fetch_count unchanged; applies even if stall=1 or imem_data is HALT_OP.
REQ-021 RUN stall=1 (no branch): pc, instr, instr_valid, fetch_count unchanged; flush=0.
REQ-022 RUN halt detect (no branch, no stall, opcode==HALT_OP): -> HALT; done<=1, instr_valid<=0, pc unchanged, halt word never issued, fetch_count unchanged.
REQ-023 HALT: all outputs frozen, done=1; branch_taken and stall ignored; start=1 -> RUN with pc=0, done<=0, fetch_count<=0, instr_valid<=0.
REQ-024 start SHALL be ignored in RUN.
REQ-025 pc increment SHALL wrap modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-026 fetch_count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 flush SHALL be 0 in every cycle not immediately following an accepted redirect; back-to-back redirects produce flush high on consecutive cycles.
REQ-028 Unknown (X) on branch_taken SHALL not be treated as a redirect; bench drives known values.

Reset
REQ-029 rst=1 at a clock edge SHALL force: state IDLE, pc=0, instr=0, instr_valid=0, flush=0, done=0, fetch_count=0, regardless of state or other inputs.
REQ-030 rst SHALL dominate start, branch_taken and stall in the same cycle; reset mid-RUN or mid-HALT discards all progress.
REQ-031 After rst deasserts, block SHALL remain in IDLE until start=1.

Verification
REQ-032 rst, start, memory 0..3 = ADD words, word 4 opcode 01011 -> instr_valid high 4 cycles, imem_addr 0,1,2,3,4, then done=1, fetch_count=4, imem_addr stays 4.
REQ-033 In RUN at pc=2, branch_taken=1, branch_target=0x10 -> next cycle imem_addr=0x10, flush=1, instr_valid=0; cycle after flush=0, fetching resumes at 0x11.
REQ-034 stall held 3 cycles at pc=5 -> imem_addr=5, instr and fetch_count unchanged for 3 cycles; resume at pc=6 after release.
REQ-035 stall=1 and branch_taken=1 same cycle, target 0x20 -> redirect taken, imem_addr=0x20, flush=1.
REQ-036 rst=1 while in RUN at pc=7 with branch_taken=1 -> next cycle IDLE, pc=0, all outputs 0; start from HALT with done=1 -> done=0, pc=0, fetch_count=0.
REQ-037 CNT_W=2, 5 consecutive issues -> fetch_count reads 1,2,3,3,3.
